conv_row_engine: RTL
====================

# conv_row_engine

Parametrised 1-D convolution compute engine: for every filter, fetches one weight word (TAPS coefficients plus bias), streams output positions from the data RAM, runs a pipelined fixed-point multiply-accumulate, and writes rounded, saturated results to the result RAM. It sits between the data/weight RAMs and the result RAM and is kicked off by the layer controller with a Start pulse. It generalises the fixed 5-tap/6-weight processor to arbitrary tap count, fraction bits, position count and filter count, with run-time sizing and explicit done/busy handshake.

## Interface
- BIT_WIDTH, 16, signed two's-complement width of data, weights, bias and result
- FRAC_BITS, 8, fractional bits of the Q format (must be ≥1 and < BIT_WIDTH)
- TAPS, 5, taps per filter (≥1)
- DEPTH_BITS, 9, position address width (max 2^DEPTH_BITS positions)
- FILTER_BITS, 3, filter address width (max 2^FILTER_BITS filters)
- Clk  in  1  single clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle request; sampled only in IDLE
- Num_positions  in  DEPTH_BITS  output positions per filter; latched at Start
- Last_filter  in  FILTER_BITS  index of last filter (filters 0..Last_filter); latched at Start
- Data_read_data  in  TAPS*BIT_WIDTH  tap k at [k*BIT_WIDTH +: BIT_WIDTH]
- Weight_read_data  in  (TAPS+1)*BIT_WIDTH  tap k at [k*BIT_WIDTH +: BIT_WIDTH], bias at top slice
- Data_RAM_address  out  DEPTH_BITS  position being read
- Data_RAM_read_en  out  1  data read strobe
- Weight_RAM_address  out  FILTER_BITS  filter being read
- Weight_RAM_read_en  out  1  weight read strobe
- Result_write_en  out  1  result write strobe
- Result_write_filter  out  FILTER_BITS  result filter address
- Result_write_position  out  DEPTH_BITS  result position address
- Result_write_data  out  BIT_WIDTH  result value
- Busy  out  1  high from cycle after accepted Start through Done cycle
- Done  out  1  one-cycle completion pulse

## Operation
- FSM: IDLE → W_FETCH → W_WAIT → STREAM → DRAIN → (W_FETCH for next filter | FINISH) → IDLE.
- IDLE: Start=1 latches Num_positions/Last_filter, clears filter counter f; if Num_positions=0 go to FINISH, else W_FETCH. Start outside IDLE is ignored.
- W_FETCH (1 cycle): Weight_RAM_read_en=1, address=f. W_WAIT (1 cycle): register Weight_read_data into coefficient/bias latches.
- STREAM: one data read per cycle, position p=0..Num_positions-1, Data_RAM_read_en=1; leave after issuing p=Num_positions-1.
- DRAIN: 4 cycles, until the last write has been emitted; then f==Last_filter → FINISH else f+1, W_FETCH.
- FINISH: Done=1 for one cycle, → IDLE.
- Arithmetic: TAPS signed products (2*BIT_WIDTH); signed sum widened by clog2(TAPS+1) bits; add bias sign-extended and shifted left FRAC_BITS; add 2^(FRAC_BITS-1) (round half up); arithmetic shift right FRAC_BITS; saturate to [−2^(BIT_WIDTH−1), 2^(BIT_WIDTH−1)−1]. No intermediate overflow is permitted.
- Result order is filter-major, positions ascending; filter/position tags travel with the pipeline.
- Reset (any time, including mid-STREAM): FSM→IDLE, counters, latches and pipeline valids cleared; every output 0 while Reset_n low and immediately after; no write may escape after reset asserts.

## Timing
- RAMs have 1-cycle read latency: data for a read issued in cycle t is valid in t+1.
- Pipeline: product reg captured end of t+1, sum reg end of t+2, result reg end of t+3; Result_write_en high in cycle t+4 (read-to-write latency 4).
- Start accepted at edge 0: W_FETCH cycle 1, W_WAIT cycle 2, first data read cycle 3, first write cycle 7.
- Per filter: 2 + Num_positions + 4 cycles; Done in cycle after the final write; total = (Last_filter+1)*(Num_positions+6)+1 cycles after Start acceptance.
- Num_positions=0: Done in cycle 2, no reads or writes.
- Throughput one result per cycle within a filter; no overlap between filters.

## Configuration
- RELU_EN defined: after saturation, negative results are written as 0.
- RELU_EN undefined: signed saturated result written unchanged. Latency identical either way.

## Structure
- Package conv_row_pkg: FSM state enum, accumulator-width constant/function (2*BIT_WIDTH+clog2(TAPS+1)), saturation bounds, DRAIN length constant (4).
- Sub-module conv_mac_pipe: 3-register multiply/sum/round-saturate datapath with valid and filter/position tag pipeline; top holds the FSM, counters and RAM interfaces.

## Test plan
- Defaults; all weights 256 (1.0), bias 0, all data 256, Num_positions=3, Last_filter=0 → three writes of 1280 at positions 0,1,2 in cycles 7,8,9; Done in cycle 10.
- Bias only: weights 0, bias 0xFF80 (−0.5) → every result 0xFF80; data 0x0001, weights 0x0080 (0.5) → half-LSB rounding checked (5*128+128 >>8 = 3).
- Saturation: data and weights all 0x7FFF → 0x7FFF; data 0x8000, weights 0x7FFF → 0x8000 (0x0000 with RELU_EN).
- Last_filter=2, Num_positions=4 → 12 writes, filter-major, addresses (0,0)…(2,3), Busy continuous, Done once at cycle 31.
- Num_positions=0 → Done in cycle 2, no read/write strobes; Start while Busy → ignored, run unaffected.
- Reset_n low mid-STREAM → all outputs 0 immediately, no further writes; new Start after release runs normally.

Source files
------------

// File: rtl/conv_row_pkg.sv
// conv_row_pkg: shared FSM encoding, accumulator sizing and saturation bounds for conv_row_engine
package conv_row_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_W_FETCH = 3'd1;
  localparam state_t S_W_WAIT  = 3'd2;
  localparam state_t S_STREAM  = 3'd3;
  localparam state_t S_DRAIN   = 3'd4;
  localparam state_t S_FINISH  = 3'd5;
  localparam int DRAIN_LEN = 4;
  function automatic int acc_width(input int bw, input int taps);
    return 2 * bw + $clog2(taps + 1);
  endfunction
  function automatic longint sat_hi(input int bw);
    return (longint'(1) <<< (bw - 1)) - 1;
  endfunction
  function automatic longint sat_lo(input int bw);
    return -(longint'(1) <<< (bw - 1));
  endfunction
endpackage

// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: multiply / sum / round-saturate datapath with valid and filter/position tags
// Ports: i_clk, i_rst_n (async active-low); i_valid/i_filter/i_pos tag a RAM read issued this
// cycle; i_data arrives one cycle later; i_coef/i_bias are the latched filter weights;
// o_valid/o_filter/o_pos/o_data emerge four cycles after the read.
// Build option: RELU_EN clamps negative results to zero after saturation.
module conv_mac_pipe
  import conv_row_pkg::*;
#(
  parameter int BIT_WIDTH   = 16,
  parameter int FRAC_BITS   = 8,
  parameter int TAPS        = 5,
  parameter int DEPTH_BITS  = 9,
  parameter int FILTER_BITS = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  input  logic [FILTER_BITS-1:0]    i_filter,
  input  logic [DEPTH_BITS-1:0]     i_pos,
  input  logic [TAPS*BIT_WIDTH-1:0] i_data,
  input  logic [TAPS*BIT_WIDTH-1:0] i_coef,
  input  logic [BIT_WIDTH-1:0]      i_bias,
  output logic                      o_valid,
  output logic [FILTER_BITS-1:0]    o_filter,
  output logic [DEPTH_BITS-1:0]     o_pos,
  output logic [BIT_WIDTH-1:0]      o_data
);
  localparam int AW = acc_width(BIT_WIDTH, TAPS);
  localparam int PW = 2 * BIT_WIDTH;
  localparam logic signed [AW-1:0] SAT_HI = AW'(sat_hi(BIT_WIDTH));
  localparam logic signed [AW-1:0] SAT_LO = AW'(sat_lo(BIT_WIDTH));
  logic                    r_v0, r_v1, r_v2;
  logic [FILTER_BITS-1:0]  r_f0, r_f1, r_f2;
  logic [DEPTH_BITS-1:0]   r_p0, r_p1, r_p2;
  logic signed [PW-1:0]    r_prod [TAPS];
  logic signed [AW-1:0]    r_sum;
  logic signed [AW-1:0]    w_sum;
  logic signed [AW-1:0]    w_shift;
  logic [BIT_WIDTH-1:0]    w_sat;
  logic [BIT_WIDTH-1:0]    w_res;
  // Bias is aligned to the product's Q position and the rounding half-LSB is folded in here
  always_comb begin
    w_sum = (AW'($signed(i_bias)) <<< FRAC_BITS) + (AW'(1) <<< (FRAC_BITS - 1));
    for (int k = 0; k < TAPS; k++) w_sum = w_sum + AW'(r_prod[k]);
  end
  assign w_shift = r_sum >>> FRAC_BITS;
  assign w_sat   = (w_shift > SAT_HI) ? SAT_HI[BIT_WIDTH-1:0] :
                   (w_shift < SAT_LO) ? SAT_LO[BIT_WIDTH-1:0] : w_shift[BIT_WIDTH-1:0];
`ifdef RELU_EN
  assign w_res = w_sat[BIT_WIDTH-1] ? '0 : w_sat;
`else
  assign w_res = w_sat;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {r_v0, r_v1, r_v2, o_valid} <= '0;
      {r_f0, r_f1, r_f2, o_filter} <= '0;
      {r_p0, r_p1, r_p2, o_pos} <= '0;
      for (int k = 0; k < TAPS; k++) r_prod[k] <= '0;
      r_sum  <= '0;
      o_data <= '0;
    end else begin
      r_v0 <= i_valid;
      r_f0 <= i_filter;
      r_p0 <= i_pos;
      r_v1 <= r_v0;
      r_f1 <= r_f0;
      r_p1 <= r_p0;
      for (int k = 0; k < TAPS; k++)
        r_prod[k] <= PW'($signed(i_data[k*BIT_WIDTH +: BIT_WIDTH])) *
                     PW'($signed(i_coef[k*BIT_WIDTH +: BIT_WIDTH]));
      r_v2     <= r_v1;
      r_f2     <= r_f1;
      r_p2     <= r_p1;
      r_sum    <= w_sum;
      o_valid  <= r_v2;
      o_filter <= r_f2;
      o_pos    <= r_p2;
      o_data   <= w_res;
    end
  end
endmodule

// File: rtl/conv_row_engine.sv
// conv_row_engine: per-filter weight fetch, position streaming and result write control for 1-D convolution
// Ports: i_clk, i_rst_n (async active-low), i_start, i_num_positions, i_last_filter,
// i_data_read_data, i_weight_read_data; o_data_ram_*, o_weight_ram_* read ports,
// o_result_write_* write port, o_busy, o_done.
// Build option: RELU_EN (handled in conv_mac_pipe) writes negative results as zero.
module conv_row_engine
  import conv_row_pkg::*;
#(
  parameter int BIT_WIDTH   = 16,
  parameter int FRAC_BITS   = 8,
  parameter int TAPS        = 5,
  parameter int DEPTH_BITS  = 9,
  parameter int FILTER_BITS = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [DEPTH_BITS-1:0]         i_num_positions,
  input  logic [FILTER_BITS-1:0]        i_last_filter,
  input  logic [TAPS*BIT_WIDTH-1:0]     i_data_read_data,
  input  logic [(TAPS+1)*BIT_WIDTH-1:0] i_weight_read_data,
  output logic [DEPTH_BITS-1:0]         o_data_ram_address,
  output logic                          o_data_ram_read_en,
  output logic [FILTER_BITS-1:0]        o_weight_ram_address,
  output logic                          o_weight_ram_read_en,
  output logic                          o_result_write_en,
  output logic [FILTER_BITS-1:0]        o_result_write_filter,
  output logic [DEPTH_BITS-1:0]         o_result_write_position,
  output logic [BIT_WIDTH-1:0]          o_result_write_data,
  output logic                          o_busy,
  output logic                          o_done
);
  state_t                          r_state;
  logic                            r_skip;
  logic [DEPTH_BITS-1:0]           r_n;
  logic [DEPTH_BITS-1:0]           r_p;
  logic [FILTER_BITS-1:0]          r_last;
  logic [FILTER_BITS-1:0]          r_f;
  logic [$clog2(DRAIN_LEN)-1:0]    r_dcnt;
  logic [TAPS*BIT_WIDTH-1:0]       r_coef;
  logic [BIT_WIDTH-1:0]            r_bias;
  // A zero-length run holds FINISH one extra cycle (r_skip) so Done lands two cycles after Start
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_skip  <= 1'b0;
      r_n     <= '0;
      r_p     <= '0;
      r_last  <= '0;
      r_f     <= '0;
      r_dcnt  <= '0;
      r_coef  <= '0;
      r_bias  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_n     <= i_num_positions;
          r_last  <= i_last_filter;
          r_f     <= '0;
          r_p     <= '0;
          r_skip  <= (i_num_positions == '0);
          r_state <= (i_num_positions == '0) ? S_FINISH : S_W_FETCH;
        end
        S_W_FETCH: r_state <= S_W_WAIT;
        S_W_WAIT: begin
          r_coef  <= i_weight_read_data[TAPS*BIT_WIDTH-1:0];
          r_bias  <= i_weight_read_data[TAPS*BIT_WIDTH +: BIT_WIDTH];
          r_p     <= '0;
          r_state <= S_STREAM;
        end
        S_STREAM: if (r_p == r_n - 1'b1) begin
          r_dcnt  <= '0;
          r_state <= S_DRAIN;
        end else begin
          r_p <= r_p + 1'b1;
        end
        S_DRAIN: if (r_dcnt == ($clog2(DRAIN_LEN))'(DRAIN_LEN - 1)) begin
          r_f     <= (r_f == r_last) ? r_f : r_f + 1'b1;
          r_state <= (r_f == r_last) ? S_FINISH : S_W_FETCH;
        end else begin
          r_dcnt <= r_dcnt + 1'b1;
        end
        S_FINISH: begin
          r_skip  <= 1'b0;
          r_state <= r_skip ? S_FINISH : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign o_data_ram_address   = r_p;
  assign o_data_ram_read_en   = (r_state == S_STREAM);
  assign o_weight_ram_address = r_f;
  assign o_weight_ram_read_en = (r_state == S_W_FETCH);
  assign o_busy               = (r_state != S_IDLE);
  assign o_done               = (r_state == S_FINISH) && !r_skip;
  conv_mac_pipe #(
    .BIT_WIDTH(BIT_WIDTH), .FRAC_BITS(FRAC_BITS), .TAPS(TAPS),
    .DEPTH_BITS(DEPTH_BITS), .FILTER_BITS(FILTER_BITS)
  ) u_pipe (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (o_data_ram_read_en),
    .i_filter (r_f),
    .i_pos    (r_p),
    .i_data   (i_data_read_data),
    .i_coef   (r_coef),
    .i_bias   (r_bias),
    .o_valid  (o_result_write_en),
    .o_filter (o_result_write_filter),
    .o_pos    (o_result_write_position),
    .o_data   (o_result_write_data)
  );
endmodule
